uart_link: RTL and testbench

//  Parametrised full-duplex UART transceiver for the board-to-board snake link on the PMOD pins.

---
 rtl/snake_uart_pkg.sv | 37 +++
 rtl/uart_fifo.sv | 51 +++++
 rtl/uart_link.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_link.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_uart_pkg.sv
// Shared types and helpers for the snake board-to-board UART link.
// Holds the parity mode, both FSM state encodings and the baud divider calculation.
package snake_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Clock cycles per oversample tick, rounded to nearest and never below 1.
    function automatic int calc_div(input longint clk_hz, input longint baud, input longint oversample);
        longint den;
        longint d;
        den = baud * oversample;
        d   = (clk_hz + den / 2) / den;
        if (d < 1) d = 1;
        return int'(d);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// Head is visible on dout whenever empty is low; push while full is only accepted with a pop.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr];

    // NOTE: storage carries no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
            else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
        end
    end

endmodule

// File: rtl/uart_link.sv
// Full-duplex UART for the snake board-to-board link: handshaked TX, FWFT-buffered RX,
// parity, start-glitch rejection, error pulses and a stretched activity indicator.
module uart_link
    import snake_uart_pkg::*;
#(
    parameter int      CLK_HZ        = 75_000_000,
    parameter int      BAUD          = 115_200,
    parameter int      OVERSAMPLE    = 16,
    parameter int      DATA_BITS     = 8,
    parameter parity_e PARITY        = PAR_NONE,
    parameter int      STOP_BITS     = 1,
    parameter int      RX_FIFO_DEPTH = 16,
    parameter int      ACT_CYCLES    = 7_500_000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rx,
    output logic                             tx,
    input  logic [DATA_BITS-1:0]             tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic [$clog2(RX_FIFO_DEPTH):0]   rx_count,
    output logic                             rx_frame_err,
    output logic                             rx_parity_err,
    output logic                             rx_overflow,
    output logic                             link_active
);
    localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int ACT_W = $clog2(ACT_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY == PAR_ODD);
    localparam bit               HAS_PAR   = (PARITY != PAR_NONE);

    // ---------------- RX tick (free running) ----------------
    logic [DIV_W-1:0] rx_div;
    logic             rx_tick;

    assign rx_tick = (rx_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_div <= '0;
        else        rx_div <= rx_tick ? '0 : rx_div + DIV_W'(1);
    end

    // ---------------- TX ----------------
    tx_state_e            tx_state, tx_state_d;
    logic [DIV_W-1:0]     tx_div;
    logic [OS_W-1:0]      tx_os;
    logic [DATA_BITS-1:0] tx_shift;
    logic [BIT_W-1:0]     tx_bit;
    logic                 tx_par;
    logic                 tx_stop_idx;
    logic                 tx_q, tx_d;
    logic                 tx_accept;
    logic                 tx_cell_end;

    assign tx_cell_end = (tx_div == DIV_LAST) && (tx_os == OS_LAST);
    assign tx_ready    = (tx_state == TX_IDLE);
    assign tx          = tx_q;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        tx_state_d = tx_state;
        tx_d       = tx_q;
        tx_accept  = 1'b0;
        unique case (tx_state)
            TX_IDLE: if (tx_valid) begin
                tx_accept  = 1'b1;
                tx_state_d = TX_START;
                tx_d       = 1'b0;
            end
            TX_START: if (tx_cell_end) begin
                tx_state_d = TX_DATA;
                tx_d       = tx_shift[0];
            end
            TX_DATA: if (tx_cell_end) begin
                if (tx_bit != BIT_LAST) begin
                    tx_d = tx_shift[1];
                end else if (HAS_PAR) begin
                    tx_state_d = TX_PARITY;
                    tx_d       = tx_par;
                end else begin
                    tx_state_d = TX_STOP;
                    tx_d       = 1'b1;
                end
            end
            TX_PARITY: if (tx_cell_end) begin
                tx_state_d = TX_STOP;
                tx_d       = 1'b1;
            end
            TX_STOP: if (tx_cell_end && (tx_stop_idx == STOP_LAST)) tx_state_d = TX_IDLE;
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // The TX tick restarts on accept so each cell is exactly DIV*OVERSAMPLE cycles long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= TX_IDLE;
            tx_q        <= 1'b1;
            tx_div      <= '0;
            tx_os       <= '0;
            tx_shift    <= '0;
            tx_bit      <= '0;
            tx_par      <= 1'b0;
            tx_stop_idx <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            tx_q     <= tx_d;
            if (tx_accept) begin
                tx_div      <= '0;
                tx_os       <= '0;
                tx_shift    <= tx_data;
                tx_bit      <= '0;
                tx_par      <= (^tx_data) ^ ODD;
                tx_stop_idx <= 1'b0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_div == DIV_LAST) begin
                    tx_div <= '0;
                    tx_os  <= (tx_os == OS_LAST) ? '0 : tx_os + OS_W'(1);
                end else begin
                    tx_div <= tx_div + DIV_W'(1);
                end
                if (tx_cell_end && tx_state == TX_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + BIT_W'(1);
                end
                if (tx_cell_end && tx_state == TX_STOP) tx_stop_idx <= 1'b1;
            end
        end
    end

    // ---------------- RX ----------------
    rx_state_e            rx_state, rx_state_d;
    logic [1:0]           rx_sync;
    logic                 rx_s, rx_prev;
    logic [OS_W-1:0]      rx_os;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par;
    logic                 rx_sample;
    logic                 rx_push;
    logic                 frame_err_d;
    logic                 parity_err_d;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign rx_s      = rx_sync[1];
    assign rx_sample = rx_tick && (rx_os == ((rx_state == RX_START) ? OS_HALF : OS_LAST));

    always_comb begin
        rx_state_d   = rx_state;
        rx_push      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        unique case (rx_state)
            RX_IDLE:   if (rx_prev && !rx_s) rx_state_d = RX_START;
            RX_START:  if (rx_sample) rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bit == BIT_LAST) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_state_d = RX_STOP;
            RX_STOP: if (rx_sample) begin
                // Only the first stop bit is checked; a second one just reads as idle line.
                rx_state_d = RX_IDLE;
                if (!rx_s)                                                 frame_err_d  = 1'b1;
                else if (HAS_PAR && (((^rx_shift) ^ ODD) != rx_par))       parity_err_d = 1'b1;
                else                                                       rx_push      = 1'b1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync       <= 2'b11;
            rx_prev       <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_os         <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_par        <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overflow   <= 1'b0;
        end else begin
            rx_sync       <= {rx_sync[0], rx};
            rx_prev       <= rx_s;
            rx_state      <= rx_state_d;
            rx_frame_err  <= frame_err_d;
            rx_parity_err <= parity_err_d;
            rx_overflow   <= rx_push && fifo_full && !rx_ready;
            if (rx_state == RX_IDLE || rx_sample) rx_os <= '0;
            else if (rx_tick)                     rx_os <= rx_os + OS_W'(1);
            if (rx_state == RX_START) rx_bit <= '0;
            if (rx_sample && rx_state == RX_DATA) begin
                rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + BIT_W'(1);
            end
            if (rx_sample && rx_state == RX_PARITY) rx_par <= rx_s;
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_ready),
        .din   (rx_shift),
        .dout  (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (rx_count)
    );

    assign rx_valid = !fifo_empty;

    // ---------------- activity stretcher ----------------
    logic [ACT_W-1:0] act_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   act_cnt <= '0;
        else if (rx_push || tx_accept) act_cnt <= ACT_W'(ACT_CYCLES);
        else if (act_cnt != '0)       act_cnt <= act_cnt - ACT_W'(1);
    end

    assign link_active = (act_cnt != '0);

endmodule

// File: tb/tb_uart_link.sv
// Self-checking bench for uart_link: a PAR_NONE instance in tx->rx loopback and a PAR_EVEN
// instance whose rx line is driven by the bench, both checked against a queue-based model.
module tb_uart_link;
    import snake_uart_pkg::*;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int OS     = 16;
    localparam int CELL   = 16;
    localparam int DEPTH  = 16;
    localparam int ACT    = 300;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       tx_n, tx_ready_n, rx_valid_n, rx_ready_n, tx_valid_n;
    logic [7:0] tx_data_n, rx_data_n;
    logic [4:0] rx_count_n;
    logic       fe_n, pe_n, ov_n, la_n;

    logic       rx_e, tx_e, tx_ready_e, rx_valid_e, rx_ready_e, tx_valid_e;
    logic [7:0] tx_data_e, rx_data_e;
    logic [4:0] rx_count_e;
    logic       fe_e, pe_e, ov_e, la_e;

    uart_link #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(PAR_NONE),
        .STOP_BITS(1), .RX_FIFO_DEPTH(DEPTH), .ACT_CYCLES(ACT)
    ) u_none (
        .clk(clk), .rst_n(rst_n), .rx(tx_n), .tx(tx_n),
        .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
        .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n), .rx_count(rx_count_n),
        .rx_frame_err(fe_n), .rx_parity_err(pe_n), .rx_overflow(ov_n), .link_active(la_n)
    );

    uart_link #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(PAR_EVEN),
        .STOP_BITS(1), .RX_FIFO_DEPTH(DEPTH), .ACT_CYCLES(ACT)
    ) u_even (
        .clk(clk), .rst_n(rst_n), .rx(rx_e), .tx(tx_e),
        .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
        .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e), .rx_count(rx_count_e),
        .rx_frame_err(fe_e), .rx_parity_err(pe_e), .rx_overflow(ov_e), .link_active(la_e)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Cycles each pulse flag was seen high; a correct pulse adds exactly one.
    int fe_e_cnt = 0, pe_e_cnt = 0, ov_e_cnt = 0, err_n_cnt = 0;
    always @(negedge clk) begin
        fe_e_cnt  += int'(fe_e);
        pe_e_cnt  += int'(pe_e);
        ov_e_cnt  += int'(ov_e);
        err_n_cnt += int'(fe_n) + int'(pe_n) + int'(ov_n);
    end

    // Reference model state
    logic [7:0] q_e[$];
    int exp_fe = 0, exp_pe = 0, exp_ov = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    task automatic send_tx(input bit sel, input logic [7:0] d);
        int w;
        w = 0;
        if (sel) begin tx_data_e = d; tx_valid_e = 1'b1; end
        else     begin tx_data_n = d; tx_valid_n = 1'b1; end
        while (!(sel ? tx_ready_e : tx_ready_n) && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("tx_ready_wait", 32'(w < 400), 1);
        @(negedge clk);
        tx_valid_e = 1'b0;
        tx_valid_n = 1'b0;
    endtask

    // Called in the first cycle after accept; walks the expected line waveform cell by cell.
    task automatic check_tx_frame(input bit sel, input logic [7:0] d);
        logic [10:0] f;
        int          ncell;
        int          lows;
        lows = 0;
        if (sel) begin f = {1'b1, even_par(d), d, 1'b0}; ncell = 11; end
        else     begin f = {1'b0, 1'b1, d, 1'b0};        ncell = 10; end
        for (int j = 0; j < CELL; j++) begin
            if (!(sel ? tx_e : tx_n)) lows++;
            @(negedge clk);
        end
        check($sformatf("tx_start_low_cycles_%02h", d), lows, CELL);
        for (int c = 1; c < ncell; c++) begin
            tick(CELL / 2);
            check($sformatf("tx_cell%0d_%02h", c, d), sel ? tx_e : tx_n, f[c]);
            tick(c == ncell - 1 ? CELL / 2 - 1 : CELL / 2);
        end
        check("tx_ready_low_in_last_stop_cycle", sel ? tx_ready_e : tx_ready_n, 0);
        @(negedge clk);
        check("tx_ready_after_stop", sel ? tx_ready_e : tx_ready_n, 1);
    endtask

    task automatic wait_valid_n(output bit ok);
        int w;
        w = 0;
        while (!rx_valid_n && w < 200) begin
            @(negedge clk);
            w++;
        end
        ok = rx_valid_n;
    endtask

    // Drives one frame onto the PAR_EVEN instance; optionally pops during the stop-sample cycle.
    task automatic inject(input logic [7:0] d, input bit flip_par, input bit bad_stop, input bit pop_at_push);
        logic [10:0] f;
        f = {~bad_stop, even_par(d) ^ flip_par, d, 1'b0};
        for (int c = 0; c < 11; c++) begin
            rx_e = f[c];
            for (int j = 0; j < CELL; j++) begin
                if (pop_at_push && c == 10 && j == 10) rx_ready_e = 1'b1;
                if (pop_at_push && c == 10 && j == 11) rx_ready_e = 1'b0;
                @(negedge clk);
            end
        end
        rx_e = 1'b1;
        tick(2 * CELL);
        // Model: frame error beats parity error; good bytes queue unless the FIFO is full.
        if (pop_at_push && q_e.size() > 0) void'(q_e.pop_front());
        if (bad_stop)                exp_fe++;
        else if (flip_par)           exp_pe++;
        else if (q_e.size() < DEPTH) q_e.push_back(d);
        else                         exp_ov++;
    endtask

    task automatic after_frame(input string tag);
        check({tag, "_count"},  rx_count_e, q_e.size());
        check({tag, "_valid"},  rx_valid_e, q_e.size() > 0);
        check({tag, "_fe"},     fe_e_cnt, exp_fe);
        check({tag, "_pe"},     pe_e_cnt, exp_pe);
        check({tag, "_ov"},     ov_e_cnt, exp_ov);
        if (q_e.size() > 0) check({tag, "_head"}, rx_data_e, q_e[0]);
    endtask

    task automatic pop_e(input string tag);
        logic [7:0] exp;
        exp = q_e.pop_front();
        check({tag, "_valid"}, rx_valid_e, 1);
        check({tag, "_data"},  rx_data_e, exp);
        rx_ready_e = 1'b1;
        @(negedge clk);
        rx_ready_e = 1'b0;
        check({tag, "_count"}, rx_count_e, q_e.size());
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        logic [7:0] d;
        int         kind;

        rst_n = 1'b0;
        rx_e = 1'b1; rx_ready_e = 1'b0; rx_ready_n = 1'b0;
        tx_valid_e = 1'b0; tx_valid_n = 1'b0; tx_data_e = '0; tx_data_n = '0;
        tick(3);
        check("rst_tx",       {tx_n, tx_e}, 2'b11);
        check("rst_tx_ready", {tx_ready_n, tx_ready_e}, 2'b11);
        check("rst_rx_valid", {rx_valid_n, rx_valid_e}, 2'b00);
        check("rst_rx_count", {rx_count_n, rx_count_e}, 10'd0);
        check("rst_flags",    {fe_n, pe_n, ov_n, fe_e, pe_e, ov_e}, 6'd0);
        check("rst_link",     {la_n, la_e}, 2'b00);
        rst_n = 1'b1;
        tick(4);

        // 1: loopback 0xA5 without parity
        send_tx(0, 8'hA5);
        check("link_active_on_accept", la_n, 1);
        check_tx_frame(0, 8'hA5);
        wait_valid_n(ok);
        check("loop_a5_valid", ok, 1);
        check("loop_a5_data",  rx_data_n, 8'hA5);
        check("loop_a5_count", rx_count_n, 1);
        rx_ready_n = 1'b1; @(negedge clk); rx_ready_n = 1'b0;
        check("loop_a5_popped", rx_count_n, 0);

        // Random loopback bytes
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            send_tx(0, d);
            tick(10 * CELL);
            wait_valid_n(ok);
            check($sformatf("loop_rand%0d_valid", i), ok, 1);
            check($sformatf("loop_rand%0d_data", i), rx_data_n, d);
            rx_ready_n = 1'b1; @(negedge clk); rx_ready_n = 1'b0;
            check($sformatf("loop_rand%0d_count", i), rx_count_n, 0);
        end
        check("loop_no_err_pulses", err_n_cnt, 0);

        // 2: even parity on TX, then a bad-parity frame on RX
        send_tx(1, 8'h07);
        check_tx_frame(1, 8'h07);
        inject(8'h07, 1'b1, 1'b0, 1'b0);
        after_frame("par_err_07");

        // 3: stop bit low; also with bad parity to show frame error wins
        inject(8'h3C, 1'b0, 1'b1, 1'b0);
        after_frame("frame_err_3c");
        inject(8'h3C, 1'b1, 1'b1, 1'b0);
        after_frame("frame_beats_parity");

        // 4: short glitch then a clean frame
        rx_e = 1'b0; tick(6); rx_e = 1'b1; tick(3 * CELL);
        after_frame("glitch");
        inject(8'h55, 1'b0, 1'b0, 1'b0);
        after_frame("after_glitch_55");
        pop_e("pop_55");

        // Random mix of good, parity-bad and stop-bad frames
        for (int i = 0; i < 10; i++) begin
            d    = 8'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 3));
            inject(d, kind == 2, kind == 3, 1'b0);
            after_frame($sformatf("rand%0d", i));
        end
        while (q_e.size() > 0) pop_e("drain_rand");

        // 5: fill, overflow, push+pop at full, then drain in order
        for (int i = 0; i <= DEPTH; i++) begin
            inject(8'(i), 1'b0, 1'b0, 1'b0);
            after_frame($sformatf("fill%0d", i));
        end
        check("full_count", rx_count_e, DEPTH);
        check("one_overflow_pulse", ov_e_cnt, 1);
        inject(8'h20, 1'b0, 1'b0, 1'b1);
        after_frame("push_pop_full");
        while (q_e.size() > 0) pop_e("drain_fill");
        check("link_active_e_after_push", la_e, 1);
        tick(ACT + 20);
        check("link_active_e_expired", la_e, 0);

        // 6: reset in the middle of a TX data cell
        inject(8'h99, 1'b0, 1'b0, 1'b0);
        after_frame("pre_reset");
        send_tx(0, 8'h00);
        tick(CELL + CELL / 2);
        check("pre_reset_tx_low", tx_n, 0);
        rst_n = 1'b0;
        #1;
        check("reset_tx_high",  tx_n, 1);
        check("reset_rx_valid", rx_valid_e, 0);
        q_e.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_tx_ready", tx_ready_n, 1);
        check("post_reset_link",     {la_n, la_e}, 2'b00);
        check("post_reset_count",    rx_count_e, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
